// File: rtl/bsa_sched_pkg.sv
// rtl/bsa_sched_pkg.sv - shared types and helpers for the binary-search scheduler
package bsa_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Result flags; the match address lives beside it because its width is a top-level parameter.
    typedef struct packed {
        logic found;
        logic timeout;
    } result_t;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             hit;
    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (!hit && req_i[cand]) begin
                hit         = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/bsa_search_scheduler.sv
// rtl/bsa_search_scheduler.sv - shares one binary-search engine between NUM_REQ requesters
module bsa_search_scheduler
    import bsa_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_target_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic                      rsp_found_o,
    output logic                      rsp_timeout_o,
    output logic [ADDR_W-1:0]         rsp_addr_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic                      eng_start_o,
    output logic [DATA_W-1:0]         eng_target_o,
    input  logic                      eng_found_i,
    input  logic                      eng_not_found_i,
    input  logic [ADDR_W-1:0]         eng_addr_i,
    output logic                      busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    result_t           res_q, res_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        addr_d      = addr_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        eng_start_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = arb_gnt;
                if (|arb_gnt) begin
                    target_d = req_target_i[arb_idx*DATA_W +: DATA_W];
                    grant_d  = arb_idx;
                    state_d  = S_START;
                end
            end
            S_START: begin
                // Engine flags seen here belong to the previous job.
                eng_start_o = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (eng_found_i) begin
                    res_d   = '{found: 1'b1, timeout: 1'b0};
                    addr_d  = eng_addr_i;
                    state_d = S_RESP;
                end else if (eng_not_found_i) begin
                    res_d   = '{found: 1'b0, timeout: 1'b0};
                    addr_d  = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '{found: 1'b0, timeout: 1'b1};
                    addr_d  = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                if (rsp_ready_i[grant_q]) begin
                    ptr_d   = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
                    res_d   = '0;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            addr_q   <= addr_d;
        end
    end

    assign rsp_found_o   = res_q.found;
    assign rsp_timeout_o = res_q.timeout;
    assign rsp_addr_o    = addr_q;
    assign eng_target_o  = target_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
